// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter: register file shared between a non-stallable SPI write
// strobe (through a one-entry pending buffer) and a req/gnt host port, with
// round-robin arbitration and a registered SPI status byte.
module reg_access_arbiter #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned REG_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [REG_W-1:0]  spi_wdata,
  input  logic              spi_wr_dv,
  output logic [REG_W-1:0]  spi_rdata,
  output logic [7:0]        spi_status,
  input  logic              spi_wr_lock,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [REG_W-1:0]  host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [REG_W-1:0]  host_rdata,
  input  logic              ovr_clr
);

  localparam int unsigned NREGS  = 1 << ADDR_W;
  localparam int unsigned DROP_W = 5;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic [REG_W-1:0]  regs_q [NREGS];

  logic              pend_v_q,      pend_v_d;
  logic [ADDR_W-1:0] pend_addr_q,   pend_addr_d;
  logic [REG_W-1:0]  pend_data_q,   pend_data_d;
  logic              rr_q,          rr_d;
  logic              overrun_q,     overrun_d;
  logic [DROP_W-1:0] drop_cnt_q,    drop_cnt_d;
  logic              lock_q,        lock_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic [REG_W-1:0]  host_rdata_q,  host_rdata_d;

  logic              spi_win, host_win;
  logic              capture, drop;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [REG_W-1:0]  wr_data;

  assign spi_rdata   = regs_q[spi_addr];
  assign spi_status  = {overrun_q, lock_q, pend_v_q, drop_cnt_q};
  assign host_gnt    = host_win;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;

  // Round-robin arbitration: on a tie the requester that did not own last wins.
  always_comb begin
    spi_win  = 1'b0;
    host_win = 1'b0;
    if (ena) begin
      if (pend_v_q && host_req) begin
        spi_win  = rr_q;
        host_win = ~rr_q;
      end else begin
        spi_win  = pend_v_q;
        host_win = host_req;
      end
    end
  end

  // Next-state for pending buffer, status fields, read port and write port.
  always_comb begin
    pend_v_d      = pend_v_q;
    pend_addr_d   = pend_addr_q;
    pend_data_d   = pend_data_q;
    rr_d          = rr_q;
    overrun_d     = overrun_q;
    drop_cnt_d    = drop_cnt_q;
    lock_d        = lock_q;
    host_rvalid_d = 1'b0;
    host_rdata_d  = host_rdata_q;
    capture       = 1'b0;
    drop          = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    if (ena) begin
      capture = spi_wr_dv & ~spi_wr_lock;
      drop    = spi_wr_dv &  spi_wr_lock;
      lock_d  = spi_wr_lock;

      if (spi_win) begin
        wr_en   = 1'b1;
        wr_addr = pend_addr_q;
        wr_data = pend_data_q;
      end else if (host_win && host_we) begin
        wr_en   = 1'b1;
        wr_addr = host_addr;
        wr_data = host_wdata;
      end

      if (spi_win) pend_v_d = 1'b0;
      // A new strobe always replaces the entry; it is only an overrun if the old one was not drained.
      if (capture) begin
        pend_v_d    = 1'b1;
        pend_addr_d = spi_addr;
        pend_data_d = spi_wdata;
        if (pend_v_q && !spi_win) overrun_d = 1'b1;
      end

      if (drop && (drop_cnt_q != DROP_MAX)) drop_cnt_d = drop_cnt_q + DROP_W'(1);

      if (host_win && !host_we) begin
        host_rvalid_d = 1'b1;
        host_rdata_d  = regs_q[host_addr];
      end

      if (spi_win || host_win) rr_d = host_win;

      if (ovr_clr) begin
        overrun_d  = 1'b0;
        drop_cnt_d = '0;
      end
    end
  end

  // Control and status state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v_q      <= 1'b0;
      pend_addr_q   <= '0;
      pend_data_q   <= '0;
      rr_q          <= 1'b0;
      overrun_q     <= 1'b0;
      drop_cnt_q    <= '0;
      lock_q        <= 1'b0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      pend_v_q      <= pend_v_d;
      pend_addr_q   <= pend_addr_d;
      pend_data_q   <= pend_data_d;
      rr_q          <= rr_d;
      overrun_q     <= overrun_d;
      drop_cnt_q    <= drop_cnt_d;
      lock_q        <= lock_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  // Register file: single write port driven by the arbitration winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter; host read data checked via scoreboard queue.
module tb_reg_access_arbiter;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned REG_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              ena;
  logic [ADDR_W-1:0] spi_addr;
  logic [REG_W-1:0]  spi_wdata;
  logic              spi_wr_dv;
  logic [REG_W-1:0]  spi_rdata;
  logic [7:0]        spi_status;
  logic              spi_wr_lock;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [REG_W-1:0]  host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [REG_W-1:0]  host_rdata;
  logic              ovr_clr;

  int n_cmp = 0;
  int n_err = 0;
  logic [REG_W-1:0] exp_q [$];
  logic [REG_W-1:0] mdl [8];

  reg_access_arbiter #(.ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_wr_dv(spi_wr_dv),
    .spi_rdata(spi_rdata), .spi_status(spi_status), .spi_wr_lock(spi_wr_lock),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                      input logic [REG_W-1:0] d);
    host_req = req; host_we = we; host_addr = a; host_wdata = d;
  endtask

  task automatic spi(input logic dv, input logic [ADDR_W-1:0] a, input logic [REG_W-1:0] d);
    spi_wr_dv = dv; spi_addr = a; spi_wdata = d;
  endtask

  task automatic rd_spi(input logic [ADDR_W-1:0] a, input logic [REG_W-1:0] exp, input string name);
    spi_addr = a;
    #1;
    chk(name, 32'(spi_rdata), 32'(exp));
  endtask

  // Monitor: every host_rvalid pulse pops and compares one expected read value.
  always @(negedge clk) begin
    if (host_rvalid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL host_rvalid_unexpected: got rdata %0h expected no pulse", host_rdata);
      end else begin
        automatic logic [REG_W-1:0] e = exp_q.pop_front();
        if (host_rdata !== e) begin
          n_err++;
          $display("FAIL host_rdata: got %0h expected %0h", host_rdata, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ena = 1'b1; spi_wr_lock = 1'b0; ovr_clr = 1'b0;
    spi(1'b0, '0, '0);
    host(1'b0, 1'b0, '0, '0);
    repeat (2) step();
    chk("rst_status", 32'(spi_status), 32'h00);
    chk("rst_gnt", 32'(host_gnt), 32'h0);
    chk("rst_rvalid", 32'(host_rvalid), 32'h0);
    chk("rst_rdata", 32'(host_rdata), 32'h00);
    chk("rst_spi_rdata", 32'(spi_rdata), 32'h00);
    rst = 1'b0;
    step();

    // SPI write, no host traffic
    spi(1'b1, 3'd3, 8'hA5);
    #1 chk("t1_gnt_n", 32'(host_gnt), 32'h0);
    step();
    spi(1'b0, 3'd3, 8'h00);
    #1 chk("t1_gnt_n1", 32'(host_gnt), 32'h0);
    chk("t1_status_pend", 32'(spi_status), 32'h20);
    step();
    rd_spi(3'd3, 8'hA5, "t1_rdata");
    chk("t1_status_done", 32'(spi_status), 32'h00);

    // Host write then read of addr 5
    host(1'b1, 1'b1, 3'd5, 8'h3C);
    #1 chk("t2_wr_gnt", 32'(host_gnt), 32'h1);
    step();
    host(1'b1, 1'b0, 3'd5, 8'h00);
    #1 chk("t2_rd_gnt", 32'(host_gnt), 32'h1);
    exp_q.push_back(8'h3C);
    step();
    host(1'b0, 1'b0, '0, '0);
    step();
    chk("t2_rvalid_pulse_end", 32'(host_rvalid), 32'h0);
    chk("t2_rdata_hold", 32'(host_rdata), 32'h3C);

    // Tie arbitration after reset: host first, then rr alternates
    rst = 1'b1; step(); rst = 1'b0; step();
    spi(1'b1, 3'd1, 8'h11);
    step();
    spi(1'b0, '0, '0);
    host(1'b1, 1'b1, 3'd2, 8'h22);
    #1 chk("t3_tie1_host", 32'(host_gnt), 32'h1);
    step();
    host(1'b1, 1'b1, 3'd3, 8'h33);
    #1 chk("t3_tie1_spi_next", 32'(host_gnt), 32'h0);
    step();
    #1 chk("t3_host_after", 32'(host_gnt), 32'h1);
    step();
    host(1'b0, 1'b0, '0, '0);
    spi(1'b1, 3'd4, 8'h44);
    step();
    spi(1'b0, '0, '0);
    host(1'b1, 1'b1, 3'd4, 8'h55);
    #1 chk("t3_tie2_spi_first", 32'(host_gnt), 32'h0);
    step();
    #1 chk("t3_tie2_host_next", 32'(host_gnt), 32'h1);
    step();
    host(1'b0, 1'b0, '0, '0);
    rd_spi(3'd4, 8'h55, "t3_later_write_wins");
    rd_spi(3'd1, 8'h11, "t3_addr1");
    rd_spi(3'd2, 8'h22, "t3_addr2");
    rd_spi(3'd3, 8'h33, "t3_addr3");

    // Overrun under continuous host traffic
    host(1'b1, 1'b1, 3'd7, 8'h77);
    spi(1'b1, 3'd6, 8'h66);
    #1 chk("t4_gnt_i", 32'(host_gnt), 32'h1);
    step();
    spi(1'b1, 3'd6, 8'h67);
    #1 chk("t4_gnt_j", 32'(host_gnt), 32'h0);
    chk("t4_status_i", 32'(spi_status), 32'h20);
    step();
    spi(1'b1, 3'd6, 8'h68);
    #1 chk("t4_gnt_k", 32'(host_gnt), 32'h1);
    chk("t4_status_no_ovr", 32'(spi_status), 32'h20);
    step();
    spi(1'b0, '0, '0);
    #1 chk("t4_gnt_l", 32'(host_gnt), 32'h0);
    chk("t4_status_ovr", 32'(spi_status), 32'hA0);
    step();
    host(1'b0, 1'b0, '0, '0);
    chk("t4_status_ovr_sticky", 32'(spi_status), 32'h80);
    rd_spi(3'd6, 8'h68, "t4_second_data");
    rd_spi(3'd7, 8'h77, "t4_host_data");
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("t4_status_clr", 32'(spi_status), 32'h00);
    host(1'b1, 1'b0, 3'd6, '0);
    exp_q.push_back(8'h68);
    step();
    host(1'b1, 1'b0, 3'd7, '0);
    exp_q.push_back(8'h77);
    step();
    host(1'b0, 1'b0, '0, '0);
    step();

    // ena=0 freezes everything
    ena = 1'b0;
    spi(1'b1, 3'd0, 8'hEE);
    host(1'b1, 1'b1, 3'd0, 8'hDD);
    #1 chk("t5_ena0_gnt", 32'(host_gnt), 32'h0);
    step();
    ena = 1'b1;
    spi(1'b0, '0, '0);
    host(1'b0, 1'b0, '0, '0);
    chk("t5_ena0_status", 32'(spi_status), 32'h00);
    rd_spi(3'd0, 8'h00, "t5_ena0_reg");
    step();

    // Locked SPI writes are dropped, drop_cnt saturates
    spi_wr_lock = 1'b1;
    for (int i = 0; i < 33; i++) begin
      spi(1'b1, 3'(i), 8'hFF);
      if (i == 1) chk("t6_status_first_drop", 32'(spi_status), 32'h41);
      step();
    end
    spi(1'b0, '0, '0);
    chk("t6_status_sat", 32'(spi_status), 32'h5F);
    mdl = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h55, 8'h00, 8'h68, 8'h77};
    for (int a = 0; a < 8; a++) rd_spi(3'(a), mdl[a], "t6_regs_unchanged");
    spi_wr_lock = 1'b0;
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("t6_status_clr", 32'(spi_status), 32'h00);

    // Reset with a pending entry and an in-flight read
    spi(1'b1, 3'd2, 8'h99);
    host(1'b1, 1'b0, 3'd1, '0);
    #1 chk("t7_gnt", 32'(host_gnt), 32'h1);
    step();
    spi(1'b0, '0, '0);
    host(1'b0, 1'b0, '0, '0);
    chk("t7_pre_rvalid", 32'(host_rvalid), 32'h1);
    chk("t7_pre_rdata", 32'(host_rdata), 32'h11);
    chk("t7_pre_status", 32'(spi_status), 32'h20);
    rst = 1'b1;
    #1;
    chk("t7_rst_rvalid", 32'(host_rvalid), 32'h0);
    chk("t7_rst_status", 32'(spi_status), 32'h00);
    chk("t7_rst_rdata", 32'(host_rdata), 32'h00);
    step();
    rst = 1'b0;
    step();
    for (int a = 0; a < 8; a++) rd_spi(3'(a), 8'h00, "t7_regs_zero");
    chk("t7_status_after", 32'(spi_status), 32'h00);
    host(1'b1, 1'b0, 3'd1, '0);
    exp_q.push_back(8'h00);
    step();
    host(1'b0, 1'b0, '0, '0);
    repeat (3) step();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_access_arbiter.md
# reg_access_arbiter

Owns the 2^ADDR_W × REG_W register file behind the SPI register slave. It shares write access between two requesters:
- the SPI slave's single-cycle write strobe, which cannot be stalled;
- an on-chip host port with a req/gnt handshake.

It serves combinational read data back to the SPI slave and builds the 8-bit status byte the slave shifts out at the start of every frame.

## Interface
Parameters:
- ADDR_W, 3, register address width; register count is 2^ADDR_W.
- REG_W, 8, register data width.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ena  in  1  global enable; when 0 all state holds and host_gnt=0.
- spi_addr  in  ADDR_W  register address from the SPI slave (read and write).
- spi_wdata  in  REG_W  write data from the SPI slave.
- spi_wr_dv  in  1  one-cycle SPI write strobe.
- spi_rdata  out  REG_W  regs[spi_addr], combinational.
- spi_status  out  8  {overrun, spi_wr_lock, pend_v, drop_cnt[4:0]}.
- spi_wr_lock  in  1  when 1, SPI writes are dropped.
- host_req  in  1  host access request; held until granted.
- host_we  in  1  1 = write, 0 = read; qualified by host_req.
- host_addr  in  ADDR_W  host register address.
- host_wdata  in  REG_W  host write data.
- host_gnt  out  1  combinational; access performed at the end of this cycle.
- host_rvalid  out  1  one-cycle pulse, read data valid.
- host_rdata  out  REG_W  read data; holds its value between pulses.
- ovr_clr  in  1  clears the overrun flag and drop_cnt.

## Operation
- Pending buffer: one entry, {pend_v, pend_addr, pend_data}.
- On spi_wr_dv=1 with spi_wr_lock=0, capture spi_addr/spi_wdata into the buffer and set pend_v.
- On spi_wr_dv=1 with spi_wr_lock=1, nothing is captured; drop_cnt increments, saturating at 31.
- Arbitration each enabled cycle between pend_v and host_req, using a last-owner bit rr (0=SPI, 1=HOST):
  - only one requester active: it wins;
  - both active: the one that is not rr wins (round-robin);
  - rr updates to the winner on every grant.
- SPI win: regs[pend_addr] <= pend_data; pend_v clears.
- Host win: host_gnt=1.
  - host_we=1: regs[host_addr] <= host_wdata.
  - host_we=0: host_rdata <= regs[host_addr] (value before any same-edge write); host_rvalid=1 next cycle.
- Simultaneous spi_wr_dv and SPI win in the same cycle: the old entry is written and the new one is loaded. pend_v stays 1 and no overrun is flagged.
- spi_wr_dv while pend_v=1 and SPI does not win: the new entry overwrites the old one (old write lost) and overrun sets (sticky).
- Same address granted in consecutive cycles: the later write wins.
- ovr_clr=1 zeroes overrun and drop_cnt. If it coincides with a drop or overrun event, the clear wins.
- ena=0: no capture, no grant, no counter change. spi_wr_dv pulses during ena=0 are ignored.

## Timing
- Reset values:
  - all regs = 0; pend_v = 0; rr = 0 (first tie goes to HOST);
  - overrun = 0; drop_cnt = 0; host_rvalid = 0; host_rdata = 0;
  - so host_gnt = 0 and spi_status = 0.
- Reset asserted mid-operation discards the pending entry and any in-flight read pulse immediately.
- SPI write latency: strobe in cycle n; the entry is pending from n+1 and committed at the end of n+1 (uncontended) or n+2 (tie lost). spi_rdata reflects the write from n+2 or n+3.
- Host write: committed at the end of the host_gnt cycle.
- Host read: host_rvalid and host_rdata valid in the cycle after host_gnt.
- Maximum host wait under continuous SPI traffic: 1 cycle.
- spi_status: registered fields, updated one cycle after the causing event.

## Test plan
- Reset, then SPI strobe addr=3 data=0xA5, no host traffic:
  - host_gnt stays 0;
  - regs[3]=0xA5 two cycles after the strobe;
  - spi_rdata=0xA5 with spi_addr=3.
- host_req write addr=5 data=0x3C, then read addr=5:
  - host_gnt in the same cycle as each request;
  - host_rvalid pulses one cycle after the read grant with host_rdata=0x3C.
- pend_v and host_req asserted together after reset:
  - host granted first, SPI the next cycle;
  - repeat the tie: SPI granted first (rr alternates).
- host_req held continuously while a second spi_wr_dv arrives with an unserved entry:
  - overrun=1, spi_status[7]=1, the second data lands;
  - ovr_clr=1 returns spi_status to 0 the next cycle.
- spi_wr_lock=1 with 33 SPI strobes:
  - no register changes;
  - drop_cnt saturates at 31 (spi_status[4:0]=5'h1F), spi_status[6]=1.
- rst asserted while pend_v=1 and a host read is granted:
  - pend_v=0, host_rvalid=0 and all regs read 0 after release.
